// File: rtl/data_descramble.sv
// data_descramble
//   Receive-side descrambler for the 802.11a bit path, s(x) = 1 + x^4 + x^7.
//   It recovers the 7-bit scrambler state from the first 7 SERVICE bits, which
//   are zero before scrambling. It then descrambles the rest of the frame one
//   bit per valid cycle. It also flags reserved SERVICE bits that descramble to 1.
//
// Ports
//   sys_clk          clock, all logic on posedge
//   sys_rstn         asynchronous active-low reset
//   descram_start    frame start pulse; loads descram_len and clears frame state
//   descram_len      total frame bits including SERVICE, sampled on descram_start
//   descram_din      scrambled input bit
//   descram_valid_i  descram_din qualifier
//   descram_dout     descrambled bit (registered)
//   descram_valid_o  descram_dout qualifier (registered)
//   descram_seed     recovered scrambler state, bit6 = first received bit
//   seed_valid       1-cycle pulse when descram_seed is updated
//   svc_err          sticky per frame: a reserved SERVICE bit descrambled to 1
//   descram_done     1-cycle pulse with the last output bit of the frame
//   dbg_state        current FSM state (IDLE=0, SEED=1, RUN=2)
//
// Stream semantics: valid-only, with no backpressure. A bit is transferred on
// every rising edge where descram_valid_i is 1. The block may not be idle and
// descram_start may not be high, or the bit is dropped. Each transferred bit
// produces exactly one descram_valid_o cycle on the following edge.
module data_descramble #(
  parameter int LEN_W    = 16,
  parameter int SVC_BITS = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rstn,
  input  logic             descram_start,
  input  logic [LEN_W-1:0] descram_len,
  input  logic             descram_din,
  input  logic             descram_valid_i,
  output logic             descram_dout,
  output logic             descram_valid_o,
  output logic [6:0]       descram_seed,
  output logic             seed_valid,
  output logic             svc_err,
  output logic             descram_done,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [6:0]       sreg_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] rem_q;

  logic accept;
  logic last_bit;
  logic seed_bit;
  logic fb;
  logic plain;
  logic in_reserved;

  assign fb          = sreg_q[6] ^ sreg_q[3];
  assign plain       = descram_din ^ fb;
  assign last_bit    = (cnt_q == rem_q - LEN_W'(1));
  assign seed_bit    = (cnt_q == LEN_W'(6));
  assign in_reserved = (cnt_q >= LEN_W'(7)) && (cnt_q < LEN_W'(SVC_BITS));
  assign dbg_state   = state_q;

  // Next state. Start wins over everything, including an in-flight frame.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    if (descram_start) begin
      state_d = (descram_len == '0) ? IDLE : SEED;
    end else begin
      case (state_q)
        SEED: begin
          if (descram_valid_i) begin
            accept = 1'b1;
            // A frame of 7 bits or fewer ends here without entering RUN.
            if (last_bit)      state_d = IDLE;
            else if (seed_bit) state_d = RUN;
          end
        end
        RUN: begin
          if (descram_valid_i) begin
            accept = 1'b1;
            if (last_bit) state_d = IDLE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q         <= IDLE;
      sreg_q          <= '0;
      cnt_q           <= '0;
      rem_q           <= '0;
      descram_dout    <= 1'b0;
      descram_valid_o <= 1'b0;
      descram_seed    <= '0;
      seed_valid      <= 1'b0;
      svc_err         <= 1'b0;
      descram_done    <= 1'b0;
    end else begin
      state_q         <= state_d;
      descram_valid_o <= 1'b0;
      seed_valid      <= 1'b0;
      descram_done    <= 1'b0;
      if (descram_start) begin
        cnt_q        <= '0;
        rem_q        <= descram_len;
        sreg_q       <= '0;
        svc_err      <= 1'b0;
        descram_seed <= '0;
        descram_dout <= 1'b0;
        // A zero-length frame completes immediately with no data.
        descram_done <= (descram_len == '0);
      end else if (accept) begin
        cnt_q           <= cnt_q + LEN_W'(1);
        descram_valid_o <= 1'b1;
        descram_done    <= last_bit;
        if (state_q == SEED) begin
          // The plain SERVICE bits here are zero, so the received bit is the
          // scrambler sequence itself. Shifting it in rebuilds the state.
          sreg_q       <= {sreg_q[5:0], descram_din};
          descram_dout <= 1'b0;
          if (seed_bit) begin
            descram_seed <= {sreg_q[5:0], descram_din};
            seed_valid   <= 1'b1;
          end
        end else begin
          sreg_q       <= {sreg_q[5:0], fb};
          descram_dout <= plain;
          if (in_reserved && plain) svc_err <= 1'b1;
        end
      end
    end
  end

endmodule
